// File: rtl/d_ff_asyn_rstn.sv
// rtl/d_ff_asyn_rstn.sv - WIDTH-bit D flip-flop bank with complementary outputs and async active-high reset
`timescale 1ns/100ps
module d_ff_asyn_rstn #(
   parameter int                 WIDTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);

   logic [WIDTH-1:0] state;

   // rstn is active-high despite its name; it is kept for port compatibility
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state <= RST_VAL;
      end else begin
         state <= D;
      end
   end

   // Both outputs come from the one register so they can never agree
   assign q    = state;
   assign qbar = ~state;

endmodule

// File: tb/tb_d_ff_asyn_rstn.sv
// tb/tb_d_ff_asyn_rstn.sv - self-checking bench for d_ff_asyn_rstn
`timescale 1ns/100ps
module tb_d_ff_asyn_rstn;

   typedef struct {
      logic rst;
      logic d;
   } vec_t;

   localparam int NVEC = 35;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic [0:0] D    = 1'b0;
   logic [0:0] q;
   logic [0:0] qbar;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic model;
   vec_t vecs[NVEC];

   d_ff_asyn_rstn dut (
      .clk  (clk),
      .rstn (rstn),
      .D    (D),
      .q    (q),
      .qbar (qbar)
   );

   always #2 clk = ~clk;

   task automatic chk(input string name, input logic e);
      checks++;
      if (q[0] !== e || qbar[0] !== ~e) begin
         errors++;
         $display("FAIL %s: q=%b qbar=%b required q=%b qbar=%b", name, q, qbar, e, ~e);
      end
   endtask

   task automatic pop_chk(input string name);
      logic e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, required an expected entry", name);
      end else begin
         e     = exp_q.pop_front();
         model = e;
         chk(name, e);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 10 random captures, then 5 rounds of 2 capture cycles plus 3 reset cycles
      for (int i = 0; i < 10; i++) begin
         vecs[i].rst = 1'b0;
         vecs[i].d   = 1'($urandom_range(0, 1));
      end
      for (int it = 0; it < 5; it++) begin
         for (int j = 0; j < 5; j++) begin
            vecs[10 + it*5 + j].rst = (j >= 2);
            vecs[10 + it*5 + j].d   = 1'($urandom_range(0, 1));
         end
      end

      #1;
      D    = 1'b1;
      rstn = 1'b1;
      #0.1 chk("reset_async", 1'b0);
      model = 1'b0;
      @(posedge clk) #1 chk("reset_across_edge", 1'b0);

      @(negedge clk);
      rstn = 1'b0;
      D    = 1'b1;
      #1 chk("release_hold", 1'b0);
      @(posedge clk) #1 chk("capture_after_release", 1'b1);
      model = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rstn = vecs[i].rst;
         D    = vecs[i].d;
         exp_q.push_back(vecs[i].rst ? 1'b0 : vecs[i].d);
         #1 chk($sformatf("vec%0d_between", i), vecs[i].rst ? 1'b0 : model);
         @(posedge clk) #1 pop_chk($sformatf("vec%0d_edge", i));
      end

      @(negedge clk);
      rstn = 1'b0;
      D    = 1'b0;
      @(posedge clk) #1 chk("hold_pre", 1'b0);
      @(negedge clk);
      D = 1'b1;
      #0.5 D = 1'b0;
      #0.5 D = 1'b1;
      #0.5 chk("hold_between", 1'b0);
      @(posedge clk) #1 chk("hold_edge", 1'b1);
      #0.5 D = 1'b0;
      #0.3 chk("hold_after_edge", 1'b1);

      @(negedge clk) D = 1'b1;
      @(posedge clk) #1 chk("mid_pre", 1'b1);
      rstn = 1'b1;
      #0.1 chk("mid_async", 1'b0);
      @(negedge clk) D = 1'b1;
      @(posedge clk) #1 chk("reset_d_toggle1", 1'b0);
      D = 1'b0;
      @(negedge clk) D = 1'b1;
      @(posedge clk) #1 chk("reset_d_toggle2", 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1 chk("mid_release_hold", 1'b0);
      @(posedge clk) #1 chk("mid_release_capture", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
